// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_BUSY,
    DM_DONE
  } dmState_t;

  localparam int DMEM_DEFAULT_LATENCY = 4;
  localparam int DMEM_DEFAULT_DEPTH   = 1024;

  // The busy counter only ever holds LATENCY-2, so $clog2(LATENCY) bits suffice.
  function automatic int cntWidth(input int latency);
    int w;
    w = $clog2(latency);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a synchronous write port and a registered, enabled read port.
// Read data holds between enabled reads; the storage itself is never reset.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic              rdEn,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[idx] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, Done/Err LATENCY cycles after acceptance.
// Stall holds the core while a request is pending; optional DMEM_ALIGN_CHECK_EN flags odd addresses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = DMEM_DEFAULT_DEPTH,
  parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              Done,
  output logic              Err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cntWidth(LATENCY);

  dmState_t          state, nextState;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [IDX_W-1:0]  latIdx, opIdx;
  logic [DATA_W-1:0] latData, opData;
  logic              latRd, latWr, latOdd;
  logic              opRd, opWr, opOdd;
  logic              req, accept, commit, opErr;
  logic              errQ;
  logic              unusedAddr;

  assign req        = MemRead | MemWrite;
  assign unusedAddr = ^{Addr[ADDR_W-1:IDX_W+1], Addr[0]};

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      DM_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            nextState = DM_DONE;
            commit    = 1'b1;
          end else begin
            nextState = DM_BUSY;
            cntNext   = CNT_W'(LATENCY - 2);
          end
        end
      end
      DM_BUSY: begin
        if (cnt == '0) begin
          nextState = DM_DONE;
          commit    = 1'b1;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      DM_DONE: nextState = DM_IDLE;
      default: nextState = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DM_IDLE;
      cnt     <= '0;
      latIdx  <= '0;
      latData <= '0;
      latRd   <= 1'b0;
      latWr   <= 1'b0;
      latOdd  <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
      errQ  <= commit & opErr;
      if (accept) begin
        latIdx  <= Addr[IDX_W:1];
        latData <= WriteData;
        latRd   <= MemRead;
        latWr   <= MemWrite;
        latOdd  <= Addr[0];
      end
    end
  end

  // With LATENCY==1 the commit happens on the accepting edge, so bypass the latches.
  always_comb begin
    if (state == DM_IDLE) begin
      opIdx  = Addr[IDX_W:1];
      opData = WriteData;
      opRd   = MemRead;
      opWr   = MemWrite;
      opOdd  = Addr[0];
    end else begin
      opIdx  = latIdx;
      opData = latData;
      opRd   = latRd;
      opWr   = latWr;
      opOdd  = latOdd;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign opErr = (opRd & opWr) | opOdd;
`else
  assign opErr = opRd & opWr;
  logic unusedOdd;
  assign unusedOdd = opOdd;
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uArray (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (rst_n & commit & opWr & ~opErr),
    .rdEn   (rst_n & commit & opRd & ~opErr),
    .idx    (opIdx),
    .wrData (opData),
    .rdData (ReadData)
  );

  assign Done  = (state == DM_DONE);
  assign Err   = errQ;
  assign Stall = rst_n & (((state == DM_IDLE) & req) | (state == DM_BUSY));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=4, DEPTH=1024.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] Addr;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        Err;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (1024),
    .LATENCY (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .Err       (Err)
  );

  // Issues one request starting just after a rising edge (cycle 0) and observes it until Done.
  // Returns at #1 after the edge that leaves the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int doneCyc, output int stallCnt, output logic errO, output logic [15:0] rdO);
    MemRead   = rd;
    MemWrite  = wr;
    Addr      = a;
    WriteData = d;
    doneCyc   = -1;
    stallCnt  = 0;
    errO      = 1'b0;
    rdO       = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (Stall) stallCnt++;
      if (Done) begin
        doneCyc = c;
        errO    = Err;
        rdO     = ReadData;
        break;
      end
      @(posedge clk);
      #1;
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int dc, sc;
    logic e;
    logic [15:0] r;
    rst_n = 1'b0;
    MemRead = 1'b1; MemWrite = 1'b0; Addr = 16'h0000; WriteData = 16'h0000;
    repeat (3) @(negedge clk);
    nCompared++;
    if (Stall !== 1'b0) begin nMismatched++; $display("FAIL reset_stall got %b want 0", Stall); end
    nCompared++;
    if (Done !== 1'b0) begin nMismatched++; $display("FAIL reset_done got %b want 0", Done); end
    nCompared++;
    if (Err !== 1'b0) begin nMismatched++; $display("FAIL reset_err got %b want 0", Err); end
    nCompared++;
    if (ReadData !== 16'h0000) begin nMismatched++; $display("FAIL reset_rdata got %h want 0000", ReadData); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b1, 1'b0, 16'h0000, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (dc !== 4) begin nMismatched++; $display("FAIL reset_release_done_cycle got %0d want 4", dc); end
  endtask

  task automatic test_store_load();
    int dc, sc;
    logic e;
    logic [15:0] r;
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, dc, sc, e, r);
    nCompared++;
    if (sc !== 4) begin nMismatched++; $display("FAIL store_stall_cycles got %0d want 4", sc); end
    nCompared++;
    if (dc !== 4) begin nMismatched++; $display("FAIL store_done_cycle got %0d want 4", dc); end
    nCompared++;
    if (e !== 1'b0) begin nMismatched++; $display("FAIL store_err got %b want 0", e); end
    access(1'b1, 1'b0, 16'h0010, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'hBEEF) begin nMismatched++; $display("FAIL load_data got %h want beef", r); end
    nCompared++;
    if (dc !== 4) begin nMismatched++; $display("FAIL load_done_cycle got %0d want 4", dc); end
    @(negedge clk);
    nCompared++;
    if (Done !== 1'b0) begin nMismatched++; $display("FAIL done_single_pulse got %b want 0", Done); end
    nCompared++;
    if (ReadData !== 16'hBEEF) begin nMismatched++; $display("FAIL rdata_hold got %h want beef", ReadData); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int dc, sc;
    logic e;
    logic [15:0] r;
    access(1'b0, 1'b1, 16'h0810, 16'h1234, dc, sc, e, r);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h1234) begin nMismatched++; $display("FAIL wrap_load got %h want 1234", r); end
  endtask

  task automatic test_conflict();
    int dc, sc;
    logic e;
    logic [15:0] r;
    access(1'b0, 1'b1, 16'h0020, 16'h7777, dc, sc, e, r);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, dc, sc, e, r);
    access(1'b1, 1'b1, 16'h0020, 16'hAAAA, dc, sc, e, r);
    nCompared++;
    if (e !== 1'b1) begin nMismatched++; $display("FAIL conflict_err got %b want 1", e); end
    nCompared++;
    if (dc !== 4) begin nMismatched++; $display("FAIL conflict_done_cycle got %0d want 4", dc); end
    nCompared++;
    if (r !== 16'h7777) begin nMismatched++; $display("FAIL conflict_rdata_kept got %h want 7777", r); end
    access(1'b1, 1'b0, 16'h0020, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h7777) begin nMismatched++; $display("FAIL conflict_no_write got %h want 7777", r); end
    nCompared++;
    if (e !== 1'b0) begin nMismatched++; $display("FAIL load_err_clear got %b want 0", e); end
  endtask

  task automatic test_abort();
    int dc, sc, doneSeen;
    logic e;
    logic [15:0] r;
    access(1'b0, 1'b1, 16'h0030, 16'h9999, dc, sc, e, r);
    MemRead = 1'b0; MemWrite = 1'b1; Addr = 16'h0030; WriteData = 16'h5555;
    doneSeen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    MemWrite = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (Done) doneSeen++;
    end
    nCompared++;
    if (doneSeen !== 0) begin nMismatched++; $display("FAIL abort_no_done got %0d pulses want 0", doneSeen); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 16'h0030, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h9999) begin nMismatched++; $display("FAIL abort_no_commit got %h want 9999", r); end
  endtask

  task automatic test_align();
    int dc, sc;
    logic e;
    logic [15:0] r;
    logic expErr;
    logic [15:0] expData;
`ifdef DMEM_ALIGN_CHECK_EN
    expErr  = 1'b1;
    expData = 16'h1111;
`else
    expErr  = 1'b0;
    expData = 16'hC0DE;
`endif
    access(1'b0, 1'b1, 16'h0040, 16'h1111, dc, sc, e, r);
    access(1'b0, 1'b1, 16'h0041, 16'hC0DE, dc, sc, e, r);
    nCompared++;
    if (e !== expErr) begin nMismatched++; $display("FAIL align_err got %b want %b", e, expErr); end
    nCompared++;
    if (dc !== 4) begin nMismatched++; $display("FAIL align_done_cycle got %0d want 4", dc); end
    access(1'b1, 1'b0, 16'h0040, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== expData) begin nMismatched++; $display("FAIL align_word got %h want %h", r, expData); end
  endtask

  task automatic test_back_to_back();
    int dc, sc;
    logic e;
    logic [15:0] r;
    access(1'b0, 1'b1, 16'h0102, 16'h4321, dc, sc, e, r);
    access(1'b1, 1'b0, 16'h0102, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h4321) begin nMismatched++; $display("FAIL b2b_load got %h want 4321", r); end
    nCompared++;
    if (sc !== 4) begin nMismatched++; $display("FAIL b2b_stall_cycles got %0d want 4", sc); end
    access(1'b0, 1'b1, 16'h0104, 16'h0F0F, dc, sc, e, r);
    access(1'b1, 1'b0, 16'h0102, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h4321) begin nMismatched++; $display("FAIL b2b_neighbour got %h want 4321", r); end
    access(1'b1, 1'b0, 16'h0104, 16'h0000, dc, sc, e, r);
    nCompared++;
    if (r !== 16'h0F0F) begin nMismatched++; $display("FAIL b2b_second_word got %h want 0f0f", r); end
  endtask

  initial begin
    rst_n = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    test_reset();
    test_store_load();
    test_wrap();
    test_conflict();
    test_abort();
    test_align();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
